// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - push/pop pointer, occupancy and flag control for a dual-port RAM FIFO
// Optional sticky overflow/underflow flag enabled by defining FIFO_ERR_EN.
module fifo_ctrl #(
    parameter int DATA_BITS       = 8,
    parameter int ADDR_BITS       = 6,
    parameter int ALMOST_FULL_TH  = 48,
    parameter int ALMOST_EMPTY_TH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic [ADDR_BITS-1:0] addr_write,
    output logic [ADDR_BITS-1:0] addr_read,
    output logic                 write,
    output logic                 read,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   fill_level,
    output logic                 valid_out,
    output logic                 error
);

    localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   AF_TH   = ALMOST_FULL_TH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   AE_TH   = ALMOST_EMPTY_TH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // DATA_BITS only documents the attached RAM word width.
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("DATA_BITS must be positive");
    end

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;

    assign full         = (count == DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign fill_level   = count;
    assign addr_write   = wr_ptr;
    assign addr_read    = rd_ptr;

    // Gating by reset keeps the RAM from seeing a strobe on the clearing edge.
    assign write = push & ~full & ~reset;
    assign read  = pop & ~empty & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (write && !read) begin
                count <= count + CNT_ONE;
            end else if (read && !write) begin
                count <= count - CNT_ONE;
            end
            valid_out <= read;
        end
    end

`ifdef FIFO_ERR_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if ((push && full) || (pop && empty)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl with a behavioural RAM
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [5:0] addr_write;
    logic [5:0] addr_read;
    logic       write;
    logic       read;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] fill_level;
    logic       valid_out;
    logic       error;

    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] mem [64];

    int n_cmp = 0;
    int n_err = 0;
    int exp_err;

    always #5 clk = ~clk;

    fifo_ctrl #(
        .DATA_BITS(8),
        .ADDR_BITS(6),
        .ALMOST_FULL_TH(48),
        .ALMOST_EMPTY_TH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .addr_write(addr_write),
        .addr_read(addr_read),
        .write(write),
        .read(read),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .fill_level(fill_level),
        .valid_out(valid_out),
        .error(error)
    );

    always @(posedge clk) begin
        if (write) mem[addr_write] <= data_in;
        if (read)  data_out <= mem[addr_read];
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef FIFO_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        reset = 1'b1; push = 1'b1; pop = 1'b0; data_in = 8'h00;
        #1;
        check("write_gated_by_reset", int'(write), 0);
        tick(); tick();
        reset = 1'b0; push = 1'b0;
        #1;
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_aempty", int'(almost_empty), 1);
        check("rst_afull", int'(almost_full), 0);
        check("rst_fill", int'(fill_level), 0);
        check("rst_waddr", int'(addr_write), 0);
        check("rst_raddr", int'(addr_read), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_error", int'(error), 0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_empty", int'(empty), 1);
        check("idle_fill", int'(fill_level), 0);
        check("idle_waddr", int'(addr_write), 0);
        check("idle_valid", int'(valid_out), 0);

        // fill to full with 0x00..0x3F
        for (int i = 0; i < 64; i++) begin
            push = 1'b1; data_in = 8'(i);
            #1;
            check("fill_write", int'(write), 1);
            tick();
            check("fill_level", int'(fill_level), i + 1);
            check("fill_afull", int'(almost_full), (i + 1 >= 48) ? 1 : 0);
            check("fill_aempty", int'(almost_empty), (i + 1 <= 8) ? 1 : 0);
            check("fill_full", int'(full), (i == 63) ? 1 : 0);
        end
        check("fill_waddr_wrap", int'(addr_write), 0);
        push = 1'b1; data_in = 8'hAA;
        #1;
        check("overflow_write", int'(write), 0);
        tick();
        push = 1'b0;
        check("overflow_fill", int'(fill_level), 64);
        check("overflow_error", int'(error), exp_err);

        // drain and check ordering
        for (int i = 0; i < 64; i++) begin
            pop = 1'b1;
            #1;
            check("drain_read", int'(read), 1);
            tick();
            check("drain_valid", int'(valid_out), 1);
            check("drain_data", int'(data_out), i);
            check("drain_fill", int'(fill_level), 63 - i);
        end
        check("drain_empty", int'(empty), 1);
        #1;
        check("underflow_read", int'(read), 0);
        tick();
        pop = 1'b0;
        check("underflow_valid", int'(valid_out), 0);
        check("underflow_fill", int'(fill_level), 0);
        check("underflow_error", int'(error), exp_err);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("clear_error", int'(error), 0);

        // simultaneous push/pop at occupancy 10
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; data_in = 8'(100 + i);
            tick();
        end
        check("sim_pre_fill", int'(fill_level), 10);
        for (int k = 0; k < 20; k++) begin
            push = 1'b1; pop = 1'b1; data_in = 8'(110 + k);
            tick();
            check("sim_fill", int'(fill_level), 10);
            check("sim_valid", int'(valid_out), 1);
            check("sim_data", int'(data_out), 100 + k);
        end
        check("sim_waddr", int'(addr_write), 30);
        check("sim_raddr", int'(addr_read), 20);
        pop = 1'b0;
        for (int i = 0; i < 54; i++) begin
            push = 1'b1; data_in = 8'(i);
            tick();
        end
        check("sim_full", int'(full), 1);
        push = 1'b1; pop = 1'b1;
        #1;
        check("full_pp_write", int'(write), 0);
        check("full_pp_read", int'(read), 1);
        tick();
        push = 1'b0; pop = 1'b0;
        check("full_pp_fill", int'(fill_level), 63);
        check("full_pp_error", int'(error), exp_err);

        // reset mid-operation at occupancy 30
        for (int i = 0; i < 33; i++) begin
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("mid_fill", int'(fill_level), 30);
        reset = 1'b1; push = 1'b1;
        tick();
        reset = 1'b0; push = 1'b0;
        check("mid_rst_fill", int'(fill_level), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_waddr", int'(addr_write), 0);
        check("mid_rst_raddr", int'(addr_read), 0);
        check("mid_rst_error", int'(error), 0);

        // wrap-around at occupancy 1
        push = 1'b1; data_in = 8'd0;
        tick();
        for (int k = 0; k < 100; k++) begin
            push = 1'b1; pop = 1'b1; data_in = 8'(k + 1);
            tick();
            check("wrap_valid", int'(valid_out), 1);
            check("wrap_data", int'(data_out), k);
            check("wrap_empty", int'(empty), 0);
            check("wrap_full", int'(full), 0);
        end
        push = 1'b0; pop = 1'b0;
        check("wrap_fill", int'(fill_level), 1);
        check("wrap_waddr", int'(addr_write), 101 % 64);
        check("wrap_raddr", int'(addr_read), 100 % 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

FIFO controller that sits directly upstream of the dual-port `ram` block (DATA_BITS=8, ADDR_BITS=6). It turns a producer/consumer push/pop interface into the RAM's `write`/`addr_write` and `read`/`addr_read` controls. It also tracks occupancy and drives full, empty and almost flags. Data does not pass through this block: the producer drives the RAM `data_in` directly, and the consumer samples RAM `data_out` when `valid_out` is high.

## Interface
Parameters:
- DATA_BITS, 8, width of the RAM data word. Carried for consistency with `ram`; no internal datapath uses it.
- ADDR_BITS, 6, RAM address width. Depth = 2^ADDR_BITS = 64.
- ALMOST_FULL_TH, 48, occupancy at or above which `almost_full` is asserted.
- ALMOST_EMPTY_TH, 8, occupancy at or below which `almost_empty` is asserted.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  producer requests a write this cycle.
- pop  in  1  consumer requests a read this cycle.
- addr_write  out  ADDR_BITS  write pointer, to RAM `addr_write`.
- addr_read  out  ADDR_BITS  read pointer, to RAM `addr_read`.
- write  out  1  accepted push, to RAM `write`.
- read  out  1  accepted pop, to RAM `read`.
- full  out  1  occupancy == 2^ADDR_BITS.
- empty  out  1  occupancy == 0.
- almost_full  out  1  occupancy >= ALMOST_FULL_TH.
- almost_empty  out  1  occupancy <= ALMOST_EMPTY_TH.
- fill_level  out  ADDR_BITS+1  current occupancy, 0..64.
- valid_out  out  1  RAM `data_out` holds the word from the previous accepted pop.
- error  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- State registers:
  - `wr_ptr` and `rd_ptr`, each ADDR_BITS wide.
  - `count`, ADDR_BITS+1 wide.
  - `valid_out`.
  - `error`.
- Acceptance is combinational from the registered flags:
  - `write = push & ~full`
  - `read = pop & ~empty`
- `addr_write = wr_ptr` and `addr_read = rd_ptr`, both taken directly from registers.
- On accepted write: `wr_ptr <= wr_ptr + 1`, wrapping modulo 2^ADDR_BITS (63 -> 0).
- On accepted read: `rd_ptr <= rd_ptr + 1`, with the same wrap.
- Occupancy update:
  - `count` +1 on write only.
  - `count` -1 on read only.
  - `count` unchanged on both or neither.
- Flags are decoded from registered `count`, so they reflect state after the previous edge.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, `count` unchanged, both pointers advance.
  - Full: only the pop is accepted; the push is rejected.
  - Empty: only the push is accepted; the pop is rejected. There is no fall-through bypass.
- Reset has priority over push/pop on the same edge. Reset mid-operation discards all contents: pointers go to 0 and the RAM contents are don't-care.
- Reset values:
  - `addr_write` = 0, `addr_read` = 0, `fill_level` = 0.
  - `empty` = 1, `full` = 0.
  - `almost_empty` = 1, `almost_full` = 0.
  - `valid_out` = 0, `error` = 0.
  - `write` and `read` are 0 during reset, since they are gated by reset.

## Timing
- Write: the RAM captures `data_in` at `addr_write` on the same edge where `write` = 1. The word is poppable from the next cycle onward, when `empty` has deasserted.
- Read: the RAM registers `data_out` on the edge where `read` = 1. `valid_out` rises one cycle after the accepted pop, i.e. read latency is 1 cycle.
- `valid_out` is high for exactly one cycle per accepted pop. Back-to-back pops give back-to-back `valid_out`.
- Flags and `fill_level` update one cycle after the accepting edge.
- Throughput: one push and one pop per cycle.

## Configuration
- `FIFO_ERR_EN` defined:
  - `error` is set on any rejected request: push while `full` (including push+pop when full) or pop while `empty`.
  - `error` stays set until `reset`.
- `FIFO_ERR_EN` undefined: the `error` port still exists and is tied to 0, and no error logic is synthesised.

## Test plan
- Reset then idle:
  - After reset, `empty`=1, `almost_empty`=1, `fill_level`=0, `addr_write`=`addr_read`=0, `valid_out`=0.
  - Outputs stay unchanged for 10 idle cycles.
- Fill to full:
  - Push 64 consecutive words 0x00..0x3F.
  - `full`=1 after the 64th edge, `addr_write` wraps to 0, `almost_full` rises when `fill_level`=48.
  - A 65th push gives `write`=0, and `error`=1 when `FIFO_ERR_EN` is defined.
- Drain and ordering:
  - From full, pop 64 words.
  - `data_out` reads 0x00..0x3F in order, each with `valid_out`=1 one cycle after its pop.
  - `empty`=1 at the end; one further pop gives `read`=0.
- Simultaneous push and pop:
  - With `fill_level`=10, assert push and pop for 20 cycles: `fill_level` stays 10 and both pointers advance by 20 modulo 64.
  - At full, push+pop gives `write`=0, `read`=1, and `fill_level` goes to 63.
- Reset mid-operation:
  - With `fill_level`=30, assert reset together with push.
  - Next cycle: `fill_level`=0, `empty`=1, pointers 0, `error`=0.
- Wrap-around:
  - Do 100 push/pop pairs at occupancy 1.
  - Data order is preserved across the 63 -> 0 pointer wrap, and `empty`/`full` never assert spuriously.
